instr_fetch_unit: RTL and testbench
===================================

# instr_fetch_unit

Instruction fetch stage of the single-cycle-ROM RISC-V core. Owns the program counter, drives the word address into the instruction ROM (combinational read, data valid in the same cycle), and buffers each fetched word with its PC in a small first-word-fall-through queue. It presents the buffered instruction/PC to decode with a valid/ready handshake, and accepts branch/jump redirects that flush the queue.

## Interface
- RESET_PC, 32'h0000_0000, PC loaded on reset; bits [1:0] must be 0.
- DEPTH, 4, queue entries; power of two, ≥ 2.
- clk  in  1  system clock, all state on rising edge.
- reset  in  1  synchronous, active-high reset.
- fetch_en  in  1  1 = fetching allowed; 0 = hold PC, no pushes.
- instr_mem_addr  out  32  byte address to ROM; equals fetch_pc register.
- instr_mem_data  in  32  ROM word at instr_mem_addr, same cycle.
- redirect_valid  in  1  1 = load new PC and flush queue.
- redirect_pc  in  32  redirect target; bits [1:0] ignored (forced 0).
- out_valid  out  1  queue non-empty.
- out_ready  in  1  decode accepts head this cycle.
- out_instr  out  32  head instruction word.
- out_pc  out  32  PC of head instruction.
- count  out  $clog2(DEPTH)+1  current occupancy, 0..DEPTH.

## Operation
- fetch_pc register drives instr_mem_addr directly (no combinational input-to-address path).
- pop = out_valid & out_ready.
- push = fetch_en & !redirect_valid & (count < DEPTH | pop). Push writes {fetch_pc, instr_mem_data} to tail; fetch_pc <= fetch_pc + 4 (32-bit wrap: 0xFFFF_FFFC -> 0x0000_0000).
- No push: fetch_pc holds.
- Redirect (priority over push): fetch_pc <= {redirect_pc[31:2], 2'b00}; queue emptied (count <= 0, pointers reset). A pop in the same cycle is honoured (consumer has taken head) and then discarded with the rest.
- Push and pop in the same cycle: count unchanged, legal at full and at count = 1.
- Queue storage is registered; out_instr/out_pc read the head entry (first-word-fall-through). Pointers wrap modulo DEPTH.
- out_valid = (count != 0). Head values are stable while out_valid & !out_ready and no redirect.
- fetch_en = 0: queue drains normally, no new fetches; re-enable resumes at held fetch_pc.

## Timing
- Reset (synchronous, any cycle, overrides everything): fetch_pc <= RESET_PC, count <= 0, pointers <= 0. Outputs after reset edge: instr_mem_addr = RESET_PC, out_valid = 0, count = 0; out_instr/out_pc = 0 (storage cleared).
- Fetch-to-decode latency: 1 cycle. Word fetched in cycle N (push at edge ending N) is out_valid in cycle N+1.
- First out_valid: first cycle after reset deasserts + 1, given fetch_en = 1.
- Steady state with out_ready = 1: one instruction per cycle, no bubbles.
- Redirect in cycle N: cycle N+1 out_valid = 0, instr_mem_addr = target; cycle N+2 out_pc = target, out_valid = 1 (if fetch_en). Redirect penalty: 1 empty cycle at output.
- Back-to-back redirects: each cycle's target wins; only last one fetched.

## Test plan
- Reset release, RESET_PC = 0, ROM[k] = 32'h1000_0000 + k, fetch_en = 1, out_ready = 1 -> out_valid rises 1 cycle after release; out_pc = 0,4,8,...; out_instr = 0x1000_0000, 0x1000_0001, ... one per cycle, no gaps.
- Backpressure: out_ready = 0 from release -> count reaches 4 after 4 cycles, instr_mem_addr stops at 0x10, head stays pc 0x0; raise out_ready -> pcs 0x0,0x4,0x8,0xC,0x10,... with no duplicates or gaps.
- Redirect_pc = 0x40 while count = 3 -> next cycle count = 0, out_valid = 0, instr_mem_addr = 0x40; following cycle out_pc = 0x40, out_instr = ROM[16].
- Redirect_pc = 0x43 -> fetch at 0x40; redirect_pc = 0xFFFF_FFFC -> out_pc sequence 0xFFFF_FFFC then 0x0000_0000.
- Redirect with simultaneous pop at full, and push+pop at full with no redirect -> respectively count = 0 next cycle; count stays 4, PC advances by 4.
- fetch_en = 0 for 5 cycles with out_ready = 1 -> queue drains to count = 0, instr_mem_addr constant; reset asserted mid-stream -> next cycle count = 0, out_valid = 0, instr_mem_addr = RESET_PC.

Source files
------------

// File: rtl/instr_fetch_unit.sv
// Fetch stage: owns the PC, reads the combinational ROM and buffers {pc, word} pairs
// in a first-word-fall-through queue that feeds decode over valid/ready.
module instr_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned DEPTH    = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     fetch_en,
    output logic [31:0]              instr_mem_addr,
    input  logic [31:0]              instr_mem_data,
    input  logic                     redirect_valid,
    input  logic [31:0]              redirect_pc,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [31:0]              out_instr,
    output logic [31:0]              out_pc,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [31:0]   pc_q, pc_d;
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic [31:0]   instr_mem_q [DEPTH];
    logic [31:0]   pc_mem_q    [DEPTH];
    logic          push, pop;

    // Low target bits are forced to zero, so they are intentionally dropped.
    logic unused_redirect_lsbs;
    assign unused_redirect_lsbs = ^redirect_pc[1:0];

    assign instr_mem_addr = pc_q;
    assign count          = count_q;
    assign out_valid      = (count_q != '0);
    assign out_instr      = instr_mem_q[rd_ptr_q];
    assign out_pc         = pc_mem_q[rd_ptr_q];

    always_comb begin
        pop      = out_valid & out_ready;
        push     = fetch_en & ~redirect_valid & ((count_q < CW'(DEPTH)) | pop);
        pc_d     = pc_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (redirect_valid) begin
            // A same-cycle pop has already been consumed; everything else is discarded.
            pc_d     = {redirect_pc[31:2], 2'b00};
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) begin
                pc_d     = pc_q + 32'd4;
                wr_ptr_d = wr_ptr_q + AW'(1);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + AW'(1);
            end
            if (push && !pop) begin
                count_d = count_q + CW'(1);
            end else if (pop && !push) begin
                count_d = count_q - CW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pc_q     <= RESET_PC;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            pc_q     <= pc_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                instr_mem_q[i] <= '0;
                pc_mem_q[i]    <= '0;
            end
        end else if (push) begin
            instr_mem_q[wr_ptr_q] <= instr_mem_data;
            pc_mem_q[wr_ptr_q]    <= pc_q;
        end
    end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit; ROM model returns 0x1000_0000 + word index.
module tb_instr_fetch_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        fetch_en;
    logic [31:0] instr_mem_addr;
    logic [31:0] instr_mem_data;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_instr;
    logic [31:0] out_pc;
    logic [2:0]  count;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    assign instr_mem_data = 32'h1000_0000 + {2'b00, instr_mem_addr[31:2]};

    instr_fetch_unit #(
        .RESET_PC (32'h0000_0000),
        .DEPTH    (4)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .fetch_en       (fetch_en),
        .instr_mem_addr (instr_mem_addr),
        .instr_mem_data (instr_mem_data),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_instr      (out_instr),
        .out_pc         (out_pc),
        .count          (count)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset          = 1'b1;
        fetch_en       = 1'b1;
        out_ready      = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
        step();
        step();
        check("rst_addr",  instr_mem_addr, 32'h0);
        check("rst_valid", 32'(out_valid), 32'd0);
        check("rst_count", 32'(count), 32'd0);
        check("rst_instr", out_instr, 32'h0);
        check("rst_pc",    out_pc, 32'h0);

        // Streaming: first valid one cycle after release, one word per cycle.
        reset = 1'b0;
        check("rel_valid", 32'(out_valid), 32'd0);
        step();
        for (int k = 0; k < 4; k++) begin
            check("str_valid", 32'(out_valid), 32'd1);
            check("str_pc",    out_pc, 32'(4 * k));
            check("str_instr", out_instr, 32'h1000_0000 + 32'(k));
            check("str_count", 32'(count), 32'd1);
            step();
        end

        // Mid-stream reset.
        reset = 1'b1;
        step();
        check("mrst_count", 32'(count), 32'd0);
        check("mrst_valid", 32'(out_valid), 32'd0);
        check("mrst_addr",  instr_mem_addr, 32'h0);

        // Backpressure from release.
        reset     = 1'b0;
        out_ready = 1'b0;
        for (int k = 0; k < 4; k++) step();
        check("bp_count", 32'(count), 32'd4);
        check("bp_addr",  instr_mem_addr, 32'h10);
        check("bp_head",  out_pc, 32'h0);
        step();
        check("bp_hold_count", 32'(count), 32'd4);
        check("bp_hold_addr",  instr_mem_addr, 32'h10);
        check("bp_hold_head",  out_pc, 32'h0);
        out_ready = 1'b1;
        step();
        check("full_pp_count", 32'(count), 32'd4);
        check("full_pp_addr",  instr_mem_addr, 32'h14);
        for (int k = 1; k < 6; k++) begin
            check("drain_pc",    out_pc, 32'(4 * k));
            check("drain_instr", out_instr, 32'h1000_0000 + 32'(k));
            step();
        end
        check("full_again", 32'(count), 32'd4);

        // Redirect with a pop at full.
        redirect_valid = 1'b1;
        redirect_pc    = 32'h40;
        step();
        check("rdf_count", 32'(count), 32'd0);
        check("rdf_valid", 32'(out_valid), 32'd0);
        check("rdf_addr",  instr_mem_addr, 32'h40);
        redirect_valid = 1'b0;
        out_ready      = 1'b0;
        step();
        check("rdf_pc",    out_pc, 32'h40);
        check("rdf_instr", out_instr, 32'h1000_0010);
        step();
        step();
        check("c3_count", 32'(count), 32'd3);

        // Redirect at count 3 with unaligned target.
        redirect_valid = 1'b1;
        redirect_pc    = 32'h43;
        step();
        check("rd3_count", 32'(count), 32'd0);
        check("rd3_valid", 32'(out_valid), 32'd0);
        check("rd3_addr",  instr_mem_addr, 32'h40);
        redirect_valid = 1'b0;
        out_ready      = 1'b1;
        step();
        check("rd3_pc",    out_pc, 32'h40);
        check("rd3_instr", out_instr, 32'h1000_0010);

        // PC wrap.
        redirect_valid = 1'b1;
        redirect_pc    = 32'hFFFF_FFFC;
        step();
        check("wrap_addr", instr_mem_addr, 32'hFFFF_FFFC);
        redirect_valid = 1'b0;
        step();
        check("wrap_pc0",    out_pc, 32'hFFFF_FFFC);
        check("wrap_instr0", out_instr, 32'h4FFF_FFFF);
        step();
        check("wrap_pc1",    out_pc, 32'h0);
        check("wrap_instr1", out_instr, 32'h1000_0000);

        // Back-to-back redirects: last target wins.
        redirect_valid = 1'b1;
        redirect_pc    = 32'h100;
        step();
        redirect_pc = 32'h200;
        step();
        check("b2b_valid", 32'(out_valid), 32'd0);
        check("b2b_addr",  instr_mem_addr, 32'h200);
        redirect_valid = 1'b0;
        step();
        check("b2b_pc0",    out_pc, 32'h200);
        check("b2b_instr0", out_instr, 32'h1000_0080);
        step();
        check("b2b_pc1", out_pc, 32'h204);

        // Fill to 3, then drain with fetch disabled.
        out_ready = 1'b0;
        step();
        step();
        check("pre_drain_count", 32'(count), 32'd3);
        fetch_en  = 1'b0;
        out_ready = 1'b1;
        for (int k = 0; k < 5; k++) begin
            if (k < 3) check("fd_pc", out_pc, 32'h204 + 32'(4 * k));
            step();
            check("fd_addr", instr_mem_addr, 32'h210);
        end
        check("fd_count", 32'(count), 32'd0);
        check("fd_valid", 32'(out_valid), 32'd0);
        fetch_en = 1'b1;
        step();
        check("resume_valid", 32'(out_valid), 32'd1);
        check("resume_pc",    out_pc, 32'h210);
        check("resume_instr", out_instr, 32'h1000_0084);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
